// File: rtl/sync_edge_detect.sv
// ----------------------------------------------------------------------------
// sync_edge_detect
//
// Brings WIDTH independent asynchronous level inputs into the i_clk domain
// through a STAGES-deep flop chain per channel. An optional per-channel glitch
// filter can follow the chain. The module also emits registered one-cycle
// rise/fall pulses that line up with the cycle where o_q first shows its new
// value.
//
// Build option:
//   SYNC_EDGE_FILTER_EN  - when defined, o_q only follows the synchroniser
//                          output after FILTER_LEN consecutive cycles of
//                          disagreement. When undefined, o_q is the last sync
//                          stage and FILTER_LEN is unused.
//
// Parameters:
//   WIDTH      - number of channels (1..32)
//   STAGES     - synchroniser flops per channel (2..4)
//   FILTER_LEN - stable cycles required by the filter (1..255)
//   RST_VAL    - per-channel reset level
//
// Ports:
//   i_clk      - sole clock, rising edge
//   i_rst      - asynchronous, active-high reset
//   i_d        - asynchronous level inputs, one bit per channel
//   o_q        - synchronised (optionally filtered) level
//   o_rise     - one-cycle pulse per channel on an o_q 0->1 transition
//   o_fall     - one-cycle pulse per channel on an o_q 1->0 transition
//   o_any_edge - OR of every o_rise and o_fall bit
// ----------------------------------------------------------------------------
module sync_edge_detect #(
   parameter int               WIDTH      = 1,
   parameter int               STAGES     = 2,
   parameter int               FILTER_LEN = 4,
   parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic             o_any_edge
);

   // Reject out-of-range configurations at elaboration time.
   if (WIDTH < 1 || WIDTH > 32 || STAGES < 2 || STAGES > 4 ||
       FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_param
      $error("sync_edge_detect: parameter out of legal range");
   end

   logic [WIDTH-1:0] sync_r [STAGES];
   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] q_cur;   // value currently shown on o_q
   logic [WIDTH-1:0] q_next;  // value o_q will take after the next edge
   logic [WIDTH-1:0] rise_r;
   logic [WIDTH-1:0] fall_r;

   // Plain flop chain with no logic between the stages, so each stage gets a
   // full cycle to resolve metastability.
   // NOTE: the chain is a small array of flops, not a RAM. Every entry is
   // reset so that no stage can leave reset holding a stale level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int s = 0; s < STAGES; s++) begin
            sync_r[s] <= RST_VAL;
         end
      end else begin
         // NOTE: non-blocking assignment makes each stage take its
         // predecessor's old value. Blocking would collapse the chain into
         // one flop.
         sync_r[0] <= i_d;
         for (int s = 1; s < STAGES; s++) begin
            sync_r[s] <= sync_r[s-1];
         end
      end
   end

   assign sync_out = sync_r[STAGES-1];

`ifdef SYNC_EDGE_FILTER_EN
   localparam int            CW       = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic [WIDTH-1:0] q_r;
   logic [CW-1:0]    cnt_r    [WIDTH];
   logic [CW-1:0]    cnt_next [WIDTH];

   // Count consecutive cycles in which the sync output disagrees with o_q.
   // The edge that would bring the count to FILTER_LEN instead loads o_q and
   // clears the count, so the counter never exceeds FILTER_LEN-1 and cannot
   // wrap. Any bounce back to the o_q value restarts the count from zero.
   always_comb begin
      // NOTE: give every output of this block a default first, so that no
      // path through the loop leaves a value unassigned and infers a latch.
      q_next = q_r;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next[i] = cnt_r[i];
         if (sync_out[i] == q_r[i]) begin
            cnt_next[i] = '0;
         end else if (cnt_r[i] == CNT_LAST) begin
            q_next[i]   = sync_out[i];
            cnt_next[i] = '0;
         end else begin
            cnt_next[i] = cnt_r[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         q_r <= RST_VAL;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         q_r <= q_next;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= cnt_next[i];
         end
      end
   end

   assign q_cur = q_r;
`else
   // Without the filter, o_q is the last stage. The value it takes next is
   // already sitting in the stage before it.
   assign q_next = sync_r[STAGES-2];
   assign q_cur  = sync_out;
`endif

   // Edge pulses come from the upcoming o_q value. They are registered on the
   // same edge that updates o_q, so each pulse appears in the first cycle o_q
   // shows its new value. Rise and fall are mutually exclusive per channel by
   // construction.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rise_r <= '0;
         fall_r <= '0;
      end else begin
         rise_r <=  q_next & ~q_cur;
         fall_r <= ~q_next &  q_cur;
      end
   end

   assign o_q        = q_cur;
   assign o_rise     = rise_r;
   assign o_fall     = fall_r;
   assign o_any_edge = |(rise_r | fall_r);

endmodule
